ifetch: RTL and testbench

- Instruction fetch sequencer for the HRM CPU; sits between the program counter register and the control/execute FSM.
- Addresses program memory with the current PC value and latches the opcode byte, plus the operand byte for two-byte instructions.
- Presents the instruction to control with a valid/ack handshake.
- Is the sole driver of the PC's wPC, branch and ijump controls, and of jmpAddr.

---
 rtl/ifetch.sv | 118 +++++++++++
 tb/tb_ifetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch sequencer: reads opcode (and operand for two-byte ops) from
// program memory at PC, hands the instruction to control, and drives PC updates.
`timescale 1ns/1ps
module ifetch #(
  parameter int         OPERAND_BIT = 7,
  parameter logic [7:0] HALT_OP     = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] PC,
  output logic [7:0] pm_addr,
  input  logic [7:0] pm_data,
  output logic [7:0] IR,
  output logic [7:0] ARG,
  output logic       ins_valid,
  input  logic       ins_ack,
  input  logic       br_en,
  input  logic       br_uncond,
  output logic [7:0] jmpAddr,
  output logic       wPC,
  output logic       branch,
  output logic       ijump,
  output logic       halted,
  output logic [2:0] state_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_LAT  = 3'd2;
  localparam logic [2:0] ARG_RD  = 3'd3;
  localparam logic [2:0] ARG_LAT = 3'd4;
  localparam logic [2:0] READY   = 3'd5;
  localparam logic [2:0] BRANCH  = 3'd6;
  localparam logic [2:0] HALTED  = 3'd7;

  logic [2:0] state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] arg_q, arg_d;
  logic       uncond_q, uncond_d;
  logic       is_halt;

  assign is_halt = (pm_data == HALT_OP);

  // Handshake: ins_valid stays high from READY entry until the edge that
  // samples ins_ack=1; ins_ack (and br_en/br_uncond with it) means nothing otherwise.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    arg_d    = arg_q;
    uncond_d = uncond_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = OP_RD;
      end
      OP_RD: begin
        state_d = OP_LAT;
      end
      OP_LAT: begin
        ir_d  = pm_data;
        arg_d = 8'h00;
        if (is_halt)                   state_d = HALTED;
        else if (pm_data[OPERAND_BIT]) state_d = ARG_RD;
        else                           state_d = READY;
      end
      ARG_RD: begin
        state_d = ARG_LAT;
      end
      ARG_LAT: begin
        arg_d   = pm_data;
        state_d = READY;
      end
      READY: begin
        if (ins_ack) begin
          uncond_d = br_en & br_uncond;
          state_d  = br_en ? BRANCH : OP_RD;
        end
      end
      BRANCH: begin
        state_d = OP_RD;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ir_q     <= 8'h00;
      arg_q    <= 8'h00;
      uncond_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      arg_q    <= arg_d;
      uncond_q <= uncond_d;
    end
  end

  // A halt opcode must not advance PC, so wPC in OP_LAT depends on the fetched byte.
  assign wPC       = ((state_q == OP_LAT) && !is_halt) ||
                     (state_q == ARG_LAT) || (state_q == BRANCH);
  assign branch    = (state_q == BRANCH);
  assign ijump     = (state_q == BRANCH) && uncond_q;
  assign ins_valid = (state_q == READY);
  assign halted    = (state_q == HALTED);
  assign pm_addr   = PC;
  assign IR        = ir_q;
  assign ARG       = arg_q;
  assign jmpAddr   = arg_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: wraps it with a program memory and PC register, and checks
// fetched instructions, latencies and PC control against a transaction-level model.
`timescale 1ns/1ps
module tb_ifetch;

  localparam logic [7:0] HALT = 8'hF0;

  logic       clk = 1'b0;
  logic       rst, start, ins_ack, br_en, br_uncond;
  logic [7:0] pc_q, pm_addr, pm_data, IR, ARG, jmpAddr;
  logic       ins_valid, wPC, branch, ijump, halted;
  logic [2:0] state_o;

  logic       alu_flag, pc_set;
  logic [7:0] pc_val;
  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic        exp_ijump = 1'b0;

  logic [7:0] m_pc, m_arg;

  ifetch dut (
    .clk(clk), .rst(rst), .start(start), .PC(pc_q), .pm_addr(pm_addr),
    .pm_data(pm_data), .IR(IR), .ARG(ARG), .ins_valid(ins_valid),
    .ins_ack(ins_ack), .br_en(br_en), .br_uncond(br_uncond), .jmpAddr(jmpAddr),
    .wPC(wPC), .branch(branch), .ijump(ijump), .halted(halted), .state_o(state_o)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pm_data <= mem[pm_addr];
    if (pc_set)   pc_q <= pc_val;
    else if (wPC) pc_q <= (branch && (ijump || alu_flag)) ? jmpAddr : pc_q + 8'd1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  initial begin
    logic        prev_valid, prev_wpc;
    logic [15:0] cur_exp;
    prev_valid = 1'b0;
    prev_wpc   = 1'b0;
    cur_exp    = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev_valid = 1'b0;
        prev_wpc   = 1'b0;
      end else begin
        if (prev_wpc) chk("wpc_consecutive", {15'd0, wPC}, 16'd0);
        if (branch) begin
          chk("branch_wpc", {15'd0, wPC}, 16'd1);
          chk("branch_ijump", {15'd0, ijump}, {15'd0, exp_ijump});
        end else begin
          chk("ijump_outside_branch", {15'd0, ijump}, 16'd0);
        end
        if (halted) chk("halted_valid", {15'd0, ins_valid}, 16'd0);
        if (ins_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ins: got IR=%0h ARG=%0h expected none", IR, ARG);
          end else begin
            cur_exp = exp_q.pop_front();
            chk("ir", {8'h0, IR}, {8'h0, cur_exp[15:8]});
            chk("arg", {8'h0, ARG}, {8'h0, cur_exp[7:0]});
            chk("jmpaddr", {8'h0, jmpAddr}, {8'h0, cur_exp[7:0]});
          end
        end else if (ins_valid) begin
          chk("ir_held", {IR, ARG}, cur_exp);
        end
        prev_valid = ins_valid;
        prev_wpc   = wPC;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pc(input logic [7:0] v);
    @(negedge clk);
    pc_set = 1'b1;
    pc_val = v;
    @(posedge clk); #1;
    pc_set = 1'b0;
    m_pc   = v;
  endtask

  task automatic do_reset(input logic with_start);
    @(negedge clk);
    rst   = 1'b1;
    start = with_start;
    @(posedge clk); #1;
    chk("rst_ir", {8'h0, IR}, 16'h0);
    chk("rst_arg", {8'h0, ARG}, 16'h0);
    chk("rst_ctrl", {10'd0, ins_valid, wPC, branch, ijump, halted, 1'b0}, 16'h0);
    chk("rst_state", {13'd0, state_o}, 16'd0);
    rst   = 1'b0;
    start = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_ack(input logic en, input logic unc, input logic flag);
    @(negedge clk);
    ins_ack   = 1'b1;
    br_en     = en;
    br_uncond = unc;
    alu_flag  = flag;
    exp_ijump = en & unc;
    @(posedge clk); #1;
    ins_ack   = 1'b0;
    br_en     = 1'b0;
    br_uncond = 1'b0;
  endtask

  // Counts edges after the start/ack edge until an instruction or halt shows;
  // stray ack/br_en before ins_valid must be ignored.
  task automatic wait_result(input int exp_lat);
    int n = 0;
    while (!(ins_valid || halted) && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (!(ins_valid || halted)) begin
        ins_ack = 1'($urandom_range(0, 1));
        br_en   = 1'($urandom_range(0, 1));
      end
    end
    ins_ack = 1'b0;
    br_en   = 1'b0;
    chk("latency", n[15:0], exp_lat[15:0]);
  endtask

  // Model: one instruction boundary (start or ack), then the following fetch.
  task automatic step(input logic use_start, input logic en, input logic unc, input logic flag);
    logic [7:0] op, arg, a1;
    int lat;
    if (!use_start && en) m_pc = (unc || flag) ? m_arg : m_pc + 8'd1;
    op  = mem[m_pc];
    a1  = m_pc + 8'd1;
    arg = (op != HALT && op[7]) ? mem[a1] : 8'h00;
    lat = (op == HALT || !op[7]) ? 2 : 4;
    if (!use_start && en) lat++;
    if (op != HALT) exp_q.push_back({op, arg});
    if (use_start) pulse_start();
    else           do_ack(en, unc, flag);
    wait_result(lat);
    if (op == HALT) begin
      chk("halt_flag", {15'd0, halted}, 16'd1);
      chk("halt_valid_low", {15'd0, ins_valid}, 16'd0);
      chk("halt_pc", {8'h0, pc_q}, {8'h0, m_pc});
    end else begin
      m_pc  = m_pc + (op[7] ? 8'd2 : 8'd1);
      m_arg = arg;
      chk("valid", {15'd0, ins_valid}, 16'd1);
      chk("pc", {8'h0, pc_q}, {8'h0, m_pc});
    end
  endtask

  task automatic hold_ready();
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
      br_en     = 1'($urandom_range(0, 1));
      br_uncond = 1'($urandom_range(0, 1));
    end
    br_en     = 1'b0;
    br_uncond = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; ins_ack = 1'b0; br_en = 1'b0; br_uncond = 1'b0;
    alu_flag = 1'b0; pc_set = 1'b0; pc_val = 8'h00; pc_q = 8'h00; pm_data = 8'h00;
    m_pc = 8'h00; m_arg = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h85; mem[8'h02] = 8'h3C;
    mem[8'h3C] = 8'h81; mem[8'h3D] = 8'h50;
    mem[8'h3F] = 8'h83; mem[8'h40] = 8'h60;
    mem[8'h60] = 8'h02; mem[8'h61] = HALT;
    repeat (2) @(posedge clk);
    do_reset(1'b0);
    set_pc(8'h00);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_ir01", {IR, ARG}, 16'h0100);
    chk("lit_pc1", {8'h0, pc_q}, 16'h0001);
    hold_ready();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_ir85", {IR, jmpAddr}, 16'h853C);
    chk("lit_pc3", {8'h0, pc_q}, 16'h0003);
    hold_ready();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("lit_uncond_target", {IR, ARG}, 16'h8150);
    chk("lit_pc3e", {8'h0, pc_q}, 16'h003E);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_fallthrough", {8'h0, pc_q}, 16'h0041);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("lit_cond_taken", {IR, 8'h0}, 16'h0200);
    chk("lit_pc61", {8'h0, pc_q}, 16'h0061);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    chk("halt_stays", {14'd0, halted, ins_valid}, 16'b10);
    chk("halt_pc_stays", {8'h0, pc_q}, 16'h0061);

    // Reset while the operand read is in progress, then operand wrap from 0xFF.
    do_reset(1'b0);
    mem[8'hFF] = 8'h9A; mem[8'h00] = 8'h55;
    set_pc(8'hFF);
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("argrd_no_valid", {15'd0, ins_valid}, 16'd0);
    do_reset(1'b0);
    set_pc(8'hFF);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_wrap", {IR, ARG}, 16'h9A55);
    chk("lit_wrap_pc", {8'h0, pc_q}, 16'h0001);

    // Reset and start together: reset wins, nothing is fetched.
    do_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_idle", {12'd0, state_o, ins_valid}, 16'd0);

    // Randomized program and handshake traffic.
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      if (mem[i] == HALT) mem[i] = 8'h0F;
    end
    set_pc(8'($urandom_range(0, 255)));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      hold_ready();
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size() > 0 ? 16'd1 : 16'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
